// File: rtl/life_grid_engine.sv
// life_grid_engine: 8x8 toroidal Conway Life board, one generation per step.
// The displayed board (r_cur) is only replaced as a whole in SWAP, so pixel reads
// always see a complete generation while the next one is built in r_nxt.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   step, reseed        1-cycle requests: compute next generation / reload SEED
//   pixel[5:0]          read address, row*8+col
//   red/green/blue_data registered colour of cur_grid[pixel], 1-clk latency
//   busy                high while a generation is being computed
//   done                1-cycle pulse when the new generation becomes visible
//   generation[15:0]    generations computed since reset/reseed
module life_grid_engine #(
  parameter logic [63:0] SEED      = 64'h0000_0000_0038_0000,
  parameter logic [23:0] ALIVE_RGB = 24'h10_10_10,
  parameter logic [23:0] DEAD_RGB  = 24'h00_00_00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic        reseed,
  input  logic [5:0]  pixel,
  output logic [7:0]  red_data,
  output logic [7:0]  green_data,
  output logic [7:0]  blue_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] generation
);

  localparam int unsigned N_CELLS = 64;
  localparam int unsigned IDX_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SWAP = 2'd2
  } state_t;

  state_t             r_state;
  logic [N_CELLS-1:0] r_cur;
  logic [N_CELLS-1:0] r_nxt;
  logic [IDX_W-1:0]   r_idx;

  logic [3:0] w_n;
  logic [2:0] w_nr;
  logic [2:0] w_nc;
  logic       w_next_cell;

  // Live-neighbour count of cell r_idx; 3-bit row/col arithmetic gives the torus wrap.
  always_comb begin
    w_n  = '0;
    w_nr = '0;
    w_nc = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        w_nr = r_idx[5:3] + 3'(dr);
        w_nc = r_idx[2:0] + 3'(dc);
        if (!(dr == 0 && dc == 0)) begin
          w_n = w_n + 4'(r_cur[{w_nr, w_nc}]);
        end
      end
    end
  end

  assign w_next_cell = (w_n == 4'd3) | (r_cur[r_idx] & (w_n == 4'd2));

  // Pixel read path, always from the displayed board.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {red_data, green_data, blue_data} <= '0;
    end else begin
      {red_data, green_data, blue_data} <= r_cur[pixel] ? ALIVE_RGB : DEAD_RGB;
    end
  end

  // Generation FSM: IDLE -> CALC (64 cells, one per clk) -> SWAP -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cur      <= SEED;
      r_nxt      <= '0;
      r_idx      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      generation <= '0;
    end else begin
      done <= 1'b0;
      if (reseed) begin
        // Reseed overrides everything, including a step on the same edge.
        r_state    <= ST_IDLE;
        r_cur      <= SEED;
        busy       <= 1'b0;
        generation <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (step) begin
              r_state <= ST_CALC;
              r_idx   <= '0;
              busy    <= 1'b1;
            end
          end
          ST_CALC: begin
            r_nxt[r_idx] <= w_next_cell;
            r_idx        <= r_idx + IDX_W'(1);
            if (r_idx == IDX_W'(N_CELLS - 1)) begin
              r_state <= ST_SWAP;
            end
          end
          ST_SWAP: begin
            r_cur      <= r_nxt;
            generation <= generation + 16'd1;
            done       <= 1'b1;
            busy       <= 1'b0;
            r_state    <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_life_grid_engine.sv
// tb_life_grid_engine: directed checks of life_grid_engine with four seeded instances
// (0 blinker, 1 glider at bottom-right corner, 2 block at cell 0, 3 empty board).
module tb_life_grid_engine;

  localparam logic [23:0] ALIVE = 24'h10_10_10;
  localparam logic [23:0] DEAD  = 24'h00_00_00;

  localparam logic [63:0] B_HORZ    = 64'h0000_0000_0038_0000; // cells 19,20,21
  localparam logic [63:0] B_VERT    = 64'h0000_0000_1010_1000; // cells 12,20,28
  localparam logic [63:0] GLIDER    = 64'hE080_4000_0000_0000; // cells 46,55,61,62,63
  localparam logic [63:0] GLIDER_S  = 64'h0180_0000_0000_00C1; // cells 55,56,0,6,7
  localparam logic [63:0] BLOCK     = 64'h0000_0000_0000_0303; // cells 0,1,8,9
  localparam logic [3:0][63:0] SEEDS = {64'h0, BLOCK, GLIDER, B_HORZ};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  step_v;
  logic [3:0]  reseed_v;
  logic [5:0]  pix [4];
  logic [23:0] rgb [4];
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [15:0] gen_v [4];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    life_grid_engine #(.SEED(SEEDS[g]), .ALIVE_RGB(ALIVE), .DEAD_RGB(DEAD)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .step       (step_v[g]),
      .reseed     (reseed_v[g]),
      .pixel      (pix[g]),
      .red_data   (rgb[g][23:16]),
      .green_data (rgb[g][15:8]),
      .blue_data  (rgb[g][7:0]),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .generation (gen_v[g])
    );
  end

  typedef struct {
    int          inst;
    int          nsteps;
    logic [63:0] exp_board;
    logic [15:0] exp_gen;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Sweep all pixels; each read is sampled one clk after the address is applied.
  task automatic check_board(input int k, input logic [63:0] exp);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pix[k] = 6'(i);
      @(posedge clk);
      #1;
      chk($sformatf("inst%0d pixel%0d", k, i), 64'(rgb[k]), 64'(exp[i] ? ALIVE : DEAD));
    end
  endtask

  task automatic wait_done(input int k);
    int lat;
    lat = 0;
    while (!done_v[k] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("step_to_done_latency", 64'(lat), 64'd65);
  endtask

  task automatic do_step(input int k);
    @(negedge clk);
    step_v[k] = 1'b1;
    @(posedge clk);
    #1;
    step_v[k] = 1'b0;
    chk("busy_after_step", 64'(busy_v[k]), 64'd1);
    wait_done(k);
  endtask

  task automatic count_done(input int k, input int cycles, output int n);
    n = 0;
    for (int e = 0; e < cycles; e++) begin
      @(posedge clk);
      #1;
      if (done_v[k]) n++;
    end
  endtask

  initial begin
    int n_done;
    int done_at;
    int bad_old;

    vecs[0] = '{0, 0, B_HORZ,   16'd0};
    vecs[1] = '{0, 1, B_VERT,   16'd1};
    vecs[2] = '{0, 1, B_HORZ,   16'd2};
    vecs[3] = '{1, 4, GLIDER_S, 16'd4};
    vecs[4] = '{2, 3, BLOCK,    16'd3};

    rst_n = 1'b0;
    step_v = '0;
    reseed_v = '0;
    for (int i = 0; i < 4; i++) pix[i] = '0;
    #23;
    chk("reset_rgb",  64'(rgb[0]),   64'd0);
    chk("reset_busy", 64'(busy_v[0]), 64'd0);
    chk("reset_done", 64'(done_v[0]), 64'd0);
    chk("reset_gen",  64'(gen_v[0]),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      for (int s = 0; s < vecs[v].nsteps; s++) do_step(vecs[v].inst);
      chk($sformatf("vec%0d_generation", v), 64'(gen_v[vecs[v].inst]), 64'(vecs[v].exp_gen));
      check_board(vecs[v].inst, vecs[v].exp_board);
    end

    // Empty board stays empty while the generation counter still advances.
    do_step(3);
    do_step(3);
    chk("empty_generation", 64'(gen_v[3]), 64'd2);
    check_board(3, 64'h0);

    // Steps at idx 10 and idx 63 are ignored; pixel 19 reads the old board until done.
    @(negedge clk);
    step_v[0] = 1'b1;
    pix[0] = 6'd19;
    @(posedge clk);
    #1;
    step_v[0] = 1'b0;
    n_done = 0;
    done_at = 0;
    bad_old = 0;
    for (int e = 1; e <= 80; e++) begin
      @(negedge clk);
      step_v[0] = (e == 11 || e == 64);
      @(posedge clk);
      #1;
      if (done_v[0]) begin
        n_done++;
        done_at = e;
      end
      if (e <= 65 && rgb[0] !== ALIVE) bad_old++;
    end
    step_v[0] = 1'b0;
    chk("busy_step_old_reads", 64'(bad_old), 64'd0);
    chk("busy_step_done_count", 64'(n_done), 64'd1);
    chk("busy_step_done_edge", 64'(done_at), 64'd65);
    chk("busy_step_generation", 64'(gen_v[0]), 64'd3);
    chk("busy_step_new_read", 64'(rgb[0]), 64'(DEAD));
    check_board(0, B_VERT);

    // Step sampled on the edge where done is high starts a new generation.
    do_step(0);
    @(negedge clk);
    step_v[0] = 1'b1;
    @(posedge clk);
    #1;
    step_v[0] = 1'b0;
    chk("step_on_done_busy", 64'(busy_v[0]), 64'd1);
    wait_done(0);
    chk("step_on_done_generation", 64'(gen_v[0]), 64'd5);
    check_board(0, B_VERT);

    // Reseed while CALC is processing idx 30.
    @(negedge clk);
    step_v[0] = 1'b1;
    @(posedge clk);
    #1;
    step_v[0] = 1'b0;
    for (int e = 1; e <= 30; e++) @(posedge clk);
    @(negedge clk);
    reseed_v[0] = 1'b1;
    @(posedge clk);
    #1;
    reseed_v[0] = 1'b0;
    chk("reseed_calc_busy", 64'(busy_v[0]), 64'd0);
    chk("reseed_calc_gen",  64'(gen_v[0]),  64'd0);
    chk("reseed_calc_done", 64'(done_v[0]), 64'd0);
    count_done(0, 80, n_done);
    chk("reseed_calc_no_done", 64'(n_done), 64'd0);
    check_board(0, B_HORZ);

    // Simultaneous step and reseed: reseed wins.
    do_step(0);
    chk("pre_reseed_gen", 64'(gen_v[0]), 64'd1);
    @(negedge clk);
    step_v[0] = 1'b1;
    reseed_v[0] = 1'b1;
    @(posedge clk);
    #1;
    step_v[0] = 1'b0;
    reseed_v[0] = 1'b0;
    chk("step_reseed_busy", 64'(busy_v[0]), 64'd0);
    chk("step_reseed_gen",  64'(gen_v[0]),  64'd0);
    count_done(0, 80, n_done);
    chk("step_reseed_no_done", 64'(n_done), 64'd0);
    check_board(0, B_HORZ);

    // Asynchronous reset in the middle of CALC restores SEED.
    do_step(0);
    @(negedge clk);
    step_v[0] = 1'b1;
    @(posedge clk);
    #1;
    step_v[0] = 1'b0;
    for (int e = 0; e < 20; e++) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midcalc_reset_busy", 64'(busy_v[0]), 64'd0);
    chk("midcalc_reset_gen",  64'(gen_v[0]),  64'd0);
    chk("midcalc_reset_rgb",  64'(rgb[0]),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(0, 80, n_done);
    chk("midcalc_reset_no_done", 64'(n_done), 64'd0);
    check_board(0, B_HORZ);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
